// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [DW-1:0] ls_rdata;
  logic          ls_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  // arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_done, ls_rdata, ls_done, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // requester/memory side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_done, ls_rdata, ls_done, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for the single-port data memory (option: ROUND_ROBIN_EN)
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          grant_ls;   // owner of the current/last transfer; doubles as last_grant
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] ls_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          if_done_q;
  logic          ls_done_q;
  logic          busy_q;
  logic          pick_ls;

  // Winner selection for a request seen in IDLE
  always_comb begin
    pick_ls = 1'b0;
`ifdef ROUND_ROBIN_EN
    // on a tie, hand the port to whoever did not have it last
    pick_ls = bus.ls_req & (~bus.if_req | ~grant_ls);
`else
    pick_ls = bus.ls_req;
`endif
  end

  // Access sequencer: capture request, hold memory drive for MEM_LAT cycles, pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      grant_ls   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ls_req | bus.if_req) begin
            state    <= ACCESS;
            grant_ls <= pick_ls;
            we_q     <= pick_ls & bus.ls_we;
            addr_q   <= pick_ls ? bus.ls_addr : bus.if_addr;
            wdata_q  <= pick_ls ? bus.ls_wdata : '0;
            cnt      <= CNT_INIT;
            mem_en_q <= 1'b1;
            mem_we_q <= pick_ls & bus.ls_we;
            busy_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!we_q) begin
              if (grant_ls) ls_rdata_q <= bus.mem_rdata;
              else          if_rdata_q <= bus.mem_rdata;
            end
            ls_done_q <= grant_ls;
            if_done_q <= ~grant_ls;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ls_done_q <= 1'b0;
          if_done_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (honours ROUND_ROBIN_EN)
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit auto_drop = 1'b1;
  bit churn = 1'b0;
  bit grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: a transfer is "ph" cycles old; 1..MEM_LAT drive memory, MEM_LAT+1 is done
  int          ph = 0;
  logic        m_ls = 1'b0;
  logic        m_we = 1'b0;
  logic        m_last_ls = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_ls_rdata = '0;

  initial begin
    logic exp_en;
    forever begin
      @(posedge clk);
      if (rst) begin
        ph = 0; m_ls = 1'b0; m_we = 1'b0; m_last_ls = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_ls_rdata = '0;
      end else if (ph == 0) begin
        if (bus.ls_req || bus.if_req) begin
`ifdef ROUND_ROBIN_EN
          m_ls = bus.ls_req && (!bus.if_req || !m_last_ls);
`else
          m_ls = bus.ls_req;
`endif
          m_last_ls = m_ls;
          m_we      = m_ls && bus.ls_we;
          m_addr    = m_ls ? bus.ls_addr : bus.if_addr;
          m_wdata   = m_ls ? bus.ls_wdata : 32'h0;
          ph        = 1;
        end
      end else if (ph <= MEM_LAT) begin
        if (ph == MEM_LAT && !m_we) begin
          if (m_ls) m_ls_rdata = bus.mem_rdata;
          else      m_if_rdata = bus.mem_rdata;
        end
        ph++;
      end else begin
        ph = 0;
      end
      #1;
      exp_en = (ph >= 1) && (ph <= MEM_LAT);
      chkb("cyc mem_en", bus.mem_en, exp_en);
      chkb("cyc mem_we", bus.mem_we, exp_en && m_we);
      if (exp_en || rst) chk("cyc mem_addr", bus.mem_addr, m_addr);
      if ((exp_en && m_we) || rst) chk("cyc mem_wdata", bus.mem_wdata, m_wdata);
      chkb("cyc if_done", bus.if_done, (ph == MEM_LAT + 1) && !m_ls);
      chkb("cyc ls_done", bus.ls_done, (ph == MEM_LAT + 1) && m_ls);
      chkb("cyc busy", bus.busy, ph != 0);
      chk("cyc if_rdata", bus.if_rdata, m_if_rdata);
      chk("cyc ls_rdata", bus.ls_rdata, m_ls_rdata);
    end
  end

  // One bench cycle: advance to the falling edge, log done pulses, act as the requesters
  task automatic step();
    @(negedge clk);
    if (bus.ls_done) grants.push_back(1'b1);
    if (bus.if_done) grants.push_back(1'b0);
    if (auto_drop) begin
      if (bus.ls_done) bus.ls_req = 1'b0;
      if (bus.if_done) bus.if_req = 1'b0;
    end
    if (churn) bus.mem_rdata = bus.mem_rdata + 32'h0101_0103;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gbase;
    int guard;
    int gsz;
    logic [3:0] exp_order;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_rdata = '0;

    // reset with noisy inputs
    for (int i = 0; i < 3; i++) begin
      step();
      bus.if_req = 1'($urandom); bus.ls_req = 1'($urandom); bus.ls_we = 1'($urandom);
      bus.if_addr = $urandom; bus.ls_addr = $urandom; bus.ls_wdata = $urandom; bus.mem_rdata = $urandom;
    end
    step();
    chkb("rst mem_en", bus.mem_en, 1'b0);
    chkb("rst busy", bus.busy, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst if_rdata", bus.if_rdata, 32'h0);
    bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.mem_rdata = '0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chkb("idle busy", bus.busy, 1'b0);
    chkb("idle mem_en", bus.mem_en, 1'b0);

    // fetch
    bus.if_addr = 32'h0000_4925; bus.mem_rdata = 32'h8C22_000A; bus.if_req = 1'b1;
    step();
    chkb("fetch c1 en", bus.mem_en, 1'b1);
    chk("fetch c1 addr", bus.mem_addr, 32'h0000_4925);
    chkb("fetch c1 we", bus.mem_we, 1'b0);
    step();
    chkb("fetch c2 en", bus.mem_en, 1'b1);
    chk("fetch c2 addr", bus.mem_addr, 32'h0000_4925);
    step();
    chkb("fetch c3 done", bus.if_done, 1'b1);
    chkb("fetch c3 en", bus.mem_en, 1'b0);
    chk("fetch rdata", bus.if_rdata, 32'h8C22_000A);
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    chkb("fetch c4 done", bus.if_done, 1'b0);
    chk("fetch rdata held", bus.if_rdata, 32'h8C22_000A);

    // store, with address change mid-access
    gsz = grants.size();
    bus.ls_we = 1'b1; bus.ls_addr = 32'h0000_0010; bus.ls_wdata = 32'h0000_000A; bus.ls_req = 1'b1;
    step();
    chkb("store c1 we", bus.mem_we, 1'b1);
    chk("store c1 wdata", bus.mem_wdata, 32'h0000_000A);
    chk("store c1 addr", bus.mem_addr, 32'h0000_0010);
    bus.ls_addr = 32'h0000_0020;
    step();
    chkb("store c2 we", bus.mem_we, 1'b1);
    chk("store c2 addr", bus.mem_addr, 32'h0000_0010);
    step();
    chkb("store done", bus.ls_done, 1'b1);
    chk("store ls_rdata", bus.ls_rdata, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("store done count", grants.size() - gsz, 1);

    // sustained tie
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    auto_drop = 1'b0; churn = 1'b1;
    bus.ls_we = 1'b0; bus.ls_addr = 32'h0000_0100; bus.if_addr = 32'h0000_0200;
    gbase = grants.size();
    bus.ls_req = 1'b1; bus.if_req = 1'b1;
    guard = 0;
    while (grants.size() < gbase + 5 && guard < 60) begin
      step();
      guard++;
      if (grants.size() == gbase + 4) bus.ls_req = 1'b0;
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("tie grant count", grants.size() - gbase, 5);
`ifdef ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    if (grants.size() >= gbase + 5) begin
      for (int i = 0; i < 4; i++) chkb("tie grant order", grants[gbase + i], exp_order[i]);
      chkb("tie if after ls drop", grants[gbase + 4], 1'b0);
    end
    auto_drop = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // reset during the second ACCESS cycle of a store
    bus.ls_we = 1'b1; bus.ls_addr = 32'h0000_0030; bus.ls_wdata = 32'h0000_0055; bus.ls_req = 1'b1;
    step();
    chkb("abort c1 en", bus.mem_en, 1'b1);
    step();
    chkb("abort c2 we", bus.mem_we, 1'b1);
    gsz = grants.size();
    rst = 1'b1; bus.ls_req = 1'b0;
    #1;
    chkb("abort en drop", bus.mem_en, 1'b0);
    chkb("abort we drop", bus.mem_we, 1'b0);
    chkb("abort busy drop", bus.busy, 1'b0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort no done", grants.size() - gsz, 0);

    // fetch after abort
    churn = 1'b0; bus.mem_rdata = 32'h1234_5678; bus.if_addr = 32'h0000_0040; bus.if_req = 1'b1;
    guard = 0;
    while (bus.if_req && guard < 10) begin
      step();
      guard++;
    end
    chkb("post-abort fetch done", bus.if_req, 1'b0);
    chk("post-abort rdata", bus.if_rdata, 32'h1234_5678);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port data memory between the instruction-fetch requester and the load/store requester of the multi-cycle CPU.
- Sequences each access over a fixed number of memory cycles and returns read data with a one-cycle done pulse.
- Sits between the fetch/memory stage control and the memory array; replaces direct per-phase drive of the memory.

Parameters:
MEM_LAT, 2, memory access cycles per transfer, legal 1..15
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req  input  1  fetch request, level, held until if_done
if_addr  input  AW  fetch address
if_rdata  output  DW  fetch read data
if_done  output  1  fetch complete, one-cycle pulse
ls_req  input  1  load/store request, level, held until ls_done
ls_we  input  1  1 = store, 0 = load
ls_addr  input  AW  load/store address
ls_wdata  input  DW  store data
ls_rdata  output  DW  load read data
ls_done  output  1  load/store complete, one-cycle pulse
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid on the last ACCESS cycle
busy  output  1  high when state != IDLE

Behaviour:
- Reset: clk and rst as above; reset is asynchronous and active-high. While rst is high, state = IDLE and all outputs are 0, including the rdata registers. The cycle counter and last_grant also reset; last_grant resets to IF.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state and captured registers.
- IDLE:
  - If ls_req and/or if_req is high, pick a winner (see arbitration).
  - Capture the winner's addr, we (0 for IF) and wdata into internal registers.
  - Load cnt = MEM_LAT-1, record the grant, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en = 1. mem_addr, mem_we and mem_wdata come from the captured registers and stay stable for all MEM_LAT cycles.
  - Requester inputs changing during ACCESS are ignored.
  - cnt decrements each cycle.
  - When cnt == 0: on a load or fetch, register mem_rdata into the granted port's rdata; go to DONE.
- DONE:
  - The granted port's done = 1 for exactly this cycle. mem_en = 0.
  - Next state is always IDLE.
- Latency and throughput:
  - done is high in cycle MEM_LAT+1 after the accepting edge.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Requester rule: the requester drops req on the edge where it samples done. A req still high in IDLE is treated as a new request.
- rdata persistence: if_rdata and ls_rdata hold their value until the next read completion on the same port. A store completion leaves ls_rdata unchanged.
- Arbitration (macro off): fixed priority, LS over IF.
- mem_we is 0 outside ACCESS. mem_addr and mem_wdata may hold stale captured values when mem_en = 0.
- Reset mid-operation: the access is aborted. mem_en and mem_we drop immediately (asynchronously), no done is issued for the aborted transfer, and the FSM restarts in IDLE.
- Width rules: addresses and data pass through unmodified, with no alignment or byte-lane logic. cnt is 4 bits.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: on a tie in IDLE (both req high), grant the port opposite to last_grant. last_grant updates on every grant. Because last_grant resets to IF, the first tie goes to LS. A lone requester is always granted.
- Undefined: fixed LS > IF priority. last_grant is not implemented.

Test Plan:
- Reset: hold rst=1 with random inputs -> all outputs 0, busy=0. Release rst -> outputs stay 0 until a request arrives.
- Fetch, MEM_LAT=2: if_req=1, if_addr=0x0000_4925, mem_rdata=0x8C22_000A ->
  - mem_en=1 and mem_addr=0x4925 for 2 cycles, mem_we=0;
  - if_done pulses in the 3rd cycle after acceptance;
  - if_rdata=0x8C22_000A, held afterward.
- Store: ls_req=1, ls_we=1, ls_addr=0x0000_0010, ls_wdata=0x0000_000A ->
  - mem_we=1, mem_wdata=0x0000_000A for 2 cycles;
  - ls_done pulses once;
  - ls_rdata unchanged.
- Tie: if_req and ls_req rise in the same cycle, repeated 4 times ->
  - macro off: LS granted every time, IF granted only after LS drops;
  - macro on: grants alternate LS, IF, LS, IF.
- Abort: assert rst during the 2nd ACCESS cycle ->
  - mem_en=0 immediately;
  - neither done ever pulses for that transfer;
  - a new fetch after reset completes normally.
- Input stability: change ls_addr from 0x10 to 0x20 mid-ACCESS -> mem_addr stays 0x10 through the transfer.
